tdm_demux4: RTL
===============

# tdm_demux4

Receive-side time-division demultiplexer for the 2:1 / 4:1 mux datapath. Accepts a serialized stream of W-bit samples, one channel per slot, with a frame-sync marker on slot 0. Steers each accepted sample to its per-channel output register and flags completed frames and sync faults. Sits at the far end of the TDM link, feeding per-channel consumers.

## Interface
- W, 8, sample width in bits
- CLK  in  1  rising-edge clock; the only clock
- RST_N  in  1  reset, asynchronous assert, active-low
- D_IN  in  W  serialized sample
- D_VALID  in  1  D_IN/FSYNC qualify this cycle
- FSYNC  in  1  high with D_VALID marks slot 0; ignored when D_VALID=0
- Y0, Y1, Y2, Y3  out  W each  per-channel sample registers
- Y_VLD  out  4  one-cycle strobe per channel: bit k means Yk was updated
- FRAME_VLD  out  1  one-cycle pulse: slots 0..3 of one frame captured without error
- SYNC_ERR  out  1  one-cycle pulse on any framing violation
- LOCKED  out  1  high while in LOCKED state

## Operation
- States: HUNT (reset state), LOCKED. 2-bit slot counter SLOT, reset 0.
- HUNT: samples with D_VALID=1, FSYNC=0 are dropped. D_VALID=1, FSYNC=1: sample goes to slot 0, SLOT<=1, go to LOCKED.
- LOCKED, per accepted sample (D_VALID=1):
  - FSYNC matches SLOT (FSYNC=1 iff SLOT=0): write sample to Y[SLOT], SLOT<=SLOT+1 (wraps 3->0).
  - FSYNC=1 with SLOT!=0 (early sync): SYNC_ERR pulse, partial frame abandoned (no FRAME_VLD), sample written to Y0, SLOT<=1, stay LOCKED.
  - FSYNC=0 with SLOT=0 (missing sync): SYNC_ERR pulse, sample dropped, SLOT<=0, go to HUNT.
- FRAME_VLD fires when slot 3 is written and slots 0..2 of the same frame were written without an intervening SYNC_ERR.
- D_VALID=0 cycles: no state change; gaps of any length are allowed mid-frame.
- Reset values: Y0..Y3=0, Y_VLD=0, FRAME_VLD=0, SYNC_ERR=0, LOCKED=0, SLOT=0, state HUNT. Reset mid-frame discards all partial data.

## Timing
- All outputs registered. Latency 1 cycle: sample accepted at edge n appears on Yk with Y_VLD[k] high after edge n+1 (one cycle wide).
- FRAME_VLD asserts in the same cycle as Y_VLD[3] for the completing sample.
- SYNC_ERR asserts 1 cycle after the offending sample; LOCKED reflects the new state in that same cycle.
- Throughput: one sample per cycle, back-to-back frames with no idle slots.
- Y registers hold their value until overwritten.

## Configuration
- Macro TDM_DEMUX_FRAME_HOLD_EN.
- Defined: slots 0..2 are written to internal staging registers. Y0..Y3 update together only on a good frame completion, with Y_VLD=4'hF and FRAME_VLD in the same cycle. Abandoned frames never reach Y outputs. Latency from slot-3 acceptance is still 1 cycle.
- Undefined: per-slot update as described in Operation. No staging registers.

## Structure
- Shared package tdm_pkg: state encoding (HUNT=0, LOCKED=1), NUM_SLOTS=4, SLOT_W=2.
- One sub-module, tdm_slot_ctr: slot counter with load-to-1, clear, and increment-with-wrap controls. The FSM and steering stay in the top module.

## Test plan
- Reset, then a clean frame A0,A1,A2,A3 (FSYNC on A0), back-to-back -> LOCKED=1 one cycle after A0. Y_VLD pulses 1,2,4,8 on consecutive cycles. FRAME_VLD with Y3=A3.
- In HUNT, send 3 samples without FSYNC, then a frame -> first 3 samples dropped, no Y_VLD. Frame is then captured normally.
- LOCKED, FSYNC asserted on slot 2 with data 8'h5A -> SYNC_ERR pulse, Y0=8'h5A, no FRAME_VLD. The next 3 samples complete a frame with FRAME_VLD.
- LOCKED, slot-0 sample arrives with FSYNC=0 -> SYNC_ERR, LOCKED=0, sample dropped, Y unchanged.
- Idle gaps of 0, 1 and 5 cycles inside a frame, plus RST_N pulled low after slot 1 -> gaps tolerated. Reset clears all outputs to 0 asynchronously and returns to HUNT.
- With TDM_DEMUX_FRAME_HOLD_EN: good frame -> single cycle with Y_VLD=4'hF and all four Y values updated. Early-sync frame -> Y0..Y3 unchanged.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM receive demultiplexer.
package tdm_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position counter: clear beats load-to-1, which beats increment-with-wrap.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic              load1_i,
    input  logic              inc_i,
    output logic [SLOT_W-1:0] slot_o
);

    logic [SLOT_W-1:0] slot_q, slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clr_i) begin
            slot_d = '0;
        end else if (load1_i) begin
            slot_d = SLOT_W'(1);
        end else if (inc_i) begin
            slot_d = slot_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: receive-side 4-slot TDM demultiplexer with frame-sync tracking.
// Define TDM_DEMUX_FRAME_HOLD_EN to stage slots 0..2 and publish whole good frames only.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [W-1:0] D_IN,
    input  logic         D_VALID,
    input  logic         FSYNC,
    output logic [W-1:0] Y0,
    output logic [W-1:0] Y1,
    output logic [W-1:0] Y2,
    output logic [W-1:0] Y3,
    output logic [3:0]   Y_VLD,
    output logic         FRAME_VLD,
    output logic         SYNC_ERR,
    output logic         LOCKED
);

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] wr_slot;
    logic              slot0, hunt_sync, lk_vld, match, early, miss;
    logic              wr_en, frame_done;
    logic              serr_q, serr_d, fvld_q, fvld_d, locked_q;
    logic [3:0]        yvld_q, yvld_d;
    logic [W-1:0]      y_q [NUM_SLOTS];
    logic [W-1:0]      y_d [NUM_SLOTS];

    assign slot0      = (slot == '0);
    assign hunt_sync  = (state_q == ST_HUNT) && D_VALID && FSYNC;
    assign lk_vld     = (state_q == ST_LOCKED) && D_VALID;
    assign match      = lk_vld && (FSYNC == slot0);
    assign early      = lk_vld && FSYNC && !slot0;
    assign miss       = lk_vld && !FSYNC && slot0;
    assign wr_en      = hunt_sync || match || early;
    assign wr_slot    = (hunt_sync || early) ? '0 : slot;
    // The counter only advances on in-order writes and every error restarts it,
    // so reaching slot 3 in order already proves slots 0..2 of this frame are intact.
    assign frame_done = match && (slot == SLOT_W'(NUM_SLOTS - 1));

    tdm_slot_ctr u_slot_ctr (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .clr_i   (miss),
        .load1_i (hunt_sync || early),
        .inc_i   (match),
        .slot_o  (slot)
    );

    always_comb begin
        state_d = state_q;
        serr_d  = early || miss;
        fvld_d  = frame_done;
        if (hunt_sync) begin
            state_d = ST_LOCKED;
        end else if (miss) begin
            state_d = ST_HUNT;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_HUNT;
            serr_q   <= 1'b0;
            fvld_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            serr_q   <= serr_d;
            fvld_q   <= fvld_d;
            locked_q <= (state_d == ST_LOCKED);
        end
    end

`ifdef TDM_DEMUX_FRAME_HOLD_EN
    logic [W-1:0] stg_q [NUM_SLOTS-1];
    logic [W-1:0] stg_d [NUM_SLOTS-1];

    always_comb begin
        stg_d  = stg_q;
        y_d    = y_q;
        yvld_d = '0;
        if (frame_done) begin
            for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                y_d[k] = stg_q[k];
            end
            y_d[NUM_SLOTS-1] = D_IN;
            yvld_d           = '1;
        end else if (wr_en) begin
            stg_d[wr_slot] = D_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < NUM_SLOTS - 1; k++) begin
                stg_q[k] <= '0;
            end
        end else begin
            stg_q <= stg_d;
        end
    end
`else
    always_comb begin
        y_d    = y_q;
        yvld_d = '0;
        if (wr_en) begin
            y_d[wr_slot]    = D_IN;
            yvld_d[wr_slot] = 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                y_q[k] <= '0;
            end
            yvld_q <= '0;
        end else begin
            y_q    <= y_d;
            yvld_q <= yvld_d;
        end
    end

    assign Y0        = y_q[0];
    assign Y1        = y_q[1];
    assign Y2        = y_q[2];
    assign Y3        = y_q[3];
    assign Y_VLD     = yvld_q;
    assign FRAME_VLD = fvld_q;
    assign SYNC_ERR  = serr_q;
    assign LOCKED    = locked_q;

endmodule
